// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-bus arbiter: FSM states, grant IDs, line offset width.
package mem_arbiter_pkg;

  localparam int unsigned LINE_OFS_BITS = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StAck  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GntIc = 2'd0,
    GntDc = 2'd1,
    GntWb = 2'd2
  } gnt_e;

endpackage

// File: rtl/mem_arb_beat_buf.sv
// Beat counter, per-beat bus address and read-line assembly buffer for mem_arbiter.
module mem_arb_beat_buf import mem_arbiter_pkg::*; #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BUS_W  = 64,
  localparam int unsigned BEATS  = LINE_W / BUS_W,
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              rdy,
  input  logic              store,
  input  logic [BUS_W-1:0]  rdata,
  input  logic [ADDR_W-1:0] line_addr,
  output logic [BEAT_W-1:0] beat,
  output logic              last_beat,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [LINE_W-1:0] line
);

  logic [BEAT_W-1:0] beat_q;
  logic [LINE_W-1:0] line_q;
  logic              unused_ofs;

  always_ff @(posedge clk) begin
    if (clr) begin
      beat_q <= '0;
      line_q <= '0;
    end else begin
      if (start) begin
        beat_q <= '0;
      end else if (rdy) begin
        beat_q <= beat_q + 1'b1;
      end
      if (store) begin
        line_q[beat_q*BUS_W +: BUS_W] <= rdata;
      end
    end
  end

  // Request offset bits are ignored: beats always walk the aligned line.
  assign unused_ofs = ^line_addr[LINE_OFS_BITS-1:0];
  assign beat_addr  = {line_addr[ADDR_W-1:LINE_OFS_BITS], LINE_OFS_BITS'(0)}
                    + ADDR_W'(beat_q) * ADDR_W'(BUS_W / 8);
  assign beat       = beat_q;
  assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));
  assign line       = line_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory bus between I-cache fills and D-cache fills/writebacks, one line per grant.
// Define MEM_ARB_RR_EN to alternate dc_miss/ic_miss round-robin (writeback stays highest).
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BUS_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_miss,
  input  logic [ADDR_W-1:0] ic_miss_addr,
  output logic              ic_miss_ack,
  output logic [LINE_W-1:0] ic_fill_data,
  input  logic              dc_miss,
  input  logic [ADDR_W-1:0] dc_miss_addr,
  output logic              dc_miss_ack,
  output logic [LINE_W-1:0] dc_fill_data,
  input  logic              dc_wb_req,
  input  logic [ADDR_W-1:0] dc_wb_addr,
  input  logic [LINE_W-1:0] dc_wb_data,
  output logic              dc_wb_ack,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BUS_W-1:0]  mem_wdata,
  input  logic [BUS_W-1:0]  mem_rdata,
  input  logic              mem_rdy
);

  localparam int unsigned BEATS  = LINE_W / BUS_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d, gnt_sel;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic [LINE_W-1:0] ic_fill_q, dc_fill_q;
  logic              any_req, start, beat_rdy, beat_store, last_beat;
  logic [BEAT_W-1:0] beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [LINE_W-1:0] line;

  assign any_req = dc_wb_req | dc_miss | ic_miss;

`ifdef MEM_ARB_RR_EN
  gnt_e last_rd_q;

  always_comb begin
    if (dc_wb_req) begin
      gnt_sel = GntWb;
    end else if (dc_miss && ic_miss) begin
      gnt_sel = (last_rd_q == GntIc) ? GntDc : GntIc;
    end else if (dc_miss) begin
      gnt_sel = GntDc;
    end else begin
      gnt_sel = GntIc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_rd_q <= GntIc;
    end else if (state_q == StIdle && any_req && gnt_sel != GntWb) begin
      last_rd_q <= gnt_sel;
    end
  end
`else
  // Writeback first so dirty data lands before a refill of the same set.
  always_comb begin
    if (dc_wb_req) begin
      gnt_sel = GntWb;
    end else if (dc_miss) begin
      gnt_sel = GntDc;
    end else begin
      gnt_sel = GntIc;
    end
  end
`endif

  always_comb begin
    case (gnt_sel)
      GntWb:   sel_addr = dc_wb_addr;
      GntDc:   sel_addr = dc_miss_addr;
      default: sel_addr = ic_miss_addr;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StXfer;
          gnt_d   = gnt_sel;
          addr_d  = sel_addr;
          start   = 1'b1;
        end
      end
      StXfer: begin
        if (mem_rdy && last_beat) begin
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= GntIc;
      addr_q    <= '0;
      ic_fill_q <= '0;
      dc_fill_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      if (ic_miss_ack) begin
        ic_fill_q <= line;
      end
      if (dc_miss_ack) begin
        dc_fill_q <= line;
      end
    end
  end

  assign beat_rdy   = (state_q == StXfer) && mem_rdy;
  assign beat_store = beat_rdy && (gnt_q != GntWb);

  mem_arb_beat_buf #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .BUS_W  (BUS_W)
  ) u_beat_buf (
    .clk       (clk),
    .clr       (!rst_n),
    .start     (start),
    .rdy       (beat_rdy),
    .store     (beat_store),
    .rdata     (mem_rdata),
    .line_addr (addr_q),
    .beat      (beat),
    .last_beat (last_beat),
    .beat_addr (beat_addr),
    .line      (line)
  );

  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ic_miss_ack  = 1'b0;
    dc_miss_ack  = 1'b0;
    dc_wb_ack    = 1'b0;
    ic_fill_data = ic_fill_q;
    dc_fill_data = dc_fill_q;
    if (state_q == StXfer) begin
      mem_req  = 1'b1;
      mem_addr = beat_addr;
      if (gnt_q == GntWb) begin
        mem_wr    = 1'b1;
        mem_wdata = dc_wb_data[beat*BUS_W +: BUS_W];
      end
    end else if (state_q == StAck) begin
      // Fill data is presented straight from the buffer in the ack cycle, then held.
      case (gnt_q)
        GntIc: begin
          ic_miss_ack  = 1'b1;
          ic_fill_data = line;
        end
        GntDc: begin
          dc_miss_ack  = 1'b1;
          dc_fill_data = line;
        end
        GntWb:   dc_wb_ack = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus multi-cycle scenarios, queue scoreboard.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    int           kind;  // 0 ic, 1 dc, 2 wb
    logic [255:0] line;
  } ack_t;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    int          stall;
    int          lat;
  } vec_t;

  logic         clk, rst_n;
  logic         ic_miss, dc_miss, dc_wb_req;
  logic [31:0]  ic_miss_addr, dc_miss_addr, dc_wb_addr;
  logic [255:0] dc_wb_data, ic_fill_data, dc_fill_data;
  logic         ic_miss_ack, dc_miss_ack, dc_wb_ack;
  logic         mem_req, mem_wr, mem_rdy;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata, mem_rdata;

  int total = 0, bad = 0, cyc = 0, last_ack_cyc = 0;
  int ic_raised = 0, dc_raised = 0, wb_raised = 0;
  int ic_acked = 0, dc_acked = 0, wb_acked = 0;
  int stall_total = 0, stall_done = 0;
  beat_t exp_beats[$];
  ack_t  exp_acks[$];

  assign ic_miss   = (ic_raised != ic_acked);
  assign dc_miss   = (dc_raised != dc_acked);
  assign dc_wb_req = (wb_raised != wb_acked);

  mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ic_miss      (ic_miss),
    .ic_miss_addr (ic_miss_addr),
    .ic_miss_ack  (ic_miss_ack),
    .ic_fill_data (ic_fill_data),
    .dc_miss      (dc_miss),
    .dc_miss_addr (dc_miss_addr),
    .dc_miss_ack  (dc_miss_ack),
    .dc_fill_data (dc_fill_data),
    .dc_wb_req    (dc_wb_req),
    .dc_wb_addr   (dc_wb_addr),
    .dc_wb_data   (dc_wb_data),
    .dc_wb_ack    (dc_wb_ack),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rdy      (mem_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [63:0] rdata_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  function automatic logic [255:0] wb_line(input logic [31:0] seed);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = seed + i * 32'h0101_0101;
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] addr);
    logic [255:0] l;
    for (int i = 0; i < 4; i++) l[i*64 +: 64] = rdata_of((addr & ~32'h1F) + i * 8);
    return l;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_xfer(input int kind, input logic [31:0] addr, input logic [255:0] wdata);
    beat_t b;
    ack_t  a;
    for (int i = 0; i < 4; i++) begin
      b.wr    = (kind == 2);
      b.addr  = (addr & ~32'h1F) + i * 8;
      b.wdata = (kind == 2) ? wdata[i*64 +: 64] : 64'h0;
      exp_beats.push_back(b);
    end
    a.kind = kind;
    a.line = line_of(addr);
    exp_acks.push_back(a);
  endtask

  task automatic raise(input int kind);
    if (kind == 0) ic_raised++;
    else if (kind == 1) dc_raised++;
    else wb_raised++;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_acks.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s: timeout, beats left %0d acks left %0d", name, exp_beats.size(),
               exp_acks.size());
      exp_beats.delete();
      exp_acks.delete();
    end
  endtask

  task automatic wait_beat(input logic [31:0] addr, input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(mem_req && mem_addr == addr) && n < 50);
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL %s: beat addr %h never seen, mem_addr %h", name, addr, mem_addr);
    end
  endtask

  // Memory model and scoreboard, both acting away from the active edge.
  initial begin
    beat_t b;
    ack_t  a;
    int    kind;
    mem_rdy   = 1'b1;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = rdata_of(mem_addr);
      if (mem_req && mem_addr[4:3] == 2'd2 && stall_done < stall_total) begin
        mem_rdy = 1'b0;
        stall_done++;
      end else begin
        mem_rdy = 1'b1;
      end
      if (mem_req) begin
        if (exp_beats.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got addr %h wr %b want no beat", mem_addr, mem_wr);
        end else begin
          b = exp_beats[0];
          check("beat_wr", mem_wr, b.wr);
          check("beat_addr", mem_addr, b.addr);
          if (b.wr) check("beat_wdata", mem_wdata, b.wdata);
          if (mem_rdy) void'(exp_beats.pop_front());
        end
      end
      if (ic_miss_ack || dc_miss_ack || dc_wb_ack) begin
        check("ack_onehot", 32'(ic_miss_ack) + 32'(dc_miss_ack) + 32'(dc_wb_ack), 1);
        check("mem_req_in_ack", mem_req, 1'b0);
        kind = dc_wb_ack ? 2 : (dc_miss_ack ? 1 : 0);
        if (exp_acks.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ack_unexpected: got kind %0d want no ack", kind);
        end else begin
          a = exp_acks.pop_front();
          check("ack_kind", kind, a.kind);
          if (kind == 0) check("ic_fill_data", ic_fill_data, a.line);
          if (kind == 1) check("dc_fill_data", dc_fill_data, a.line);
        end
        last_ack_cyc = cyc;
        if (ic_miss_ack) ic_acked++;
        if (dc_miss_ack) dc_acked++;
        if (dc_wb_ack)   wb_acked++;
      end
    end
  end

  initial begin
    vec_t         vecs[5];
    int           req_cyc, l_ic, l_dc, last, pick;
    logic [255:0] wd;

    // Latency counts clock edges from the request cycle to the ack cycle.
    vecs[0] = '{kind: 0, addr: 32'h0000_1234, stall: 0, lat: 5};
    vecs[1] = '{kind: 1, addr: 32'h8000_001F, stall: 0, lat: 5};
    vecs[2] = '{kind: 2, addr: 32'h0000_0040, stall: 0, lat: 5};
    vecs[3] = '{kind: 2, addr: 32'h1234_5678, stall: 3, lat: 8};
    vecs[4] = '{kind: 0, addr: 32'hFFFF_FFE7, stall: 3, lat: 8};

    rst_n        = 1'b0;
    ic_miss_addr = '0;
    dc_miss_addr = '0;
    dc_wb_addr   = '0;
    dc_wb_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_acks", {ic_miss_ack, dc_miss_ack, dc_wb_ack}, 3'b000);
    check("rst_ic_fill", ic_fill_data, 256'h0);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      wd = wb_line(vecs[i].addr);
      if (vecs[i].kind == 0) ic_miss_addr = vecs[i].addr;
      if (vecs[i].kind == 1) dc_miss_addr = vecs[i].addr;
      if (vecs[i].kind == 2) begin
        dc_wb_addr = vecs[i].addr;
        dc_wb_data = wd;
      end
      push_xfer(vecs[i].kind, vecs[i].addr, wd);
      stall_total += vecs[i].stall;
      req_cyc = cyc;
      raise(vecs[i].kind);
      wait_done("vec");
      check("vec_latency", last_ack_cyc - req_cyc, vecs[i].lat);
    end
    check("dc_fill_hold", dc_fill_data, line_of(32'h8000_001F));

    // All three requesters at once: writeback, then dc read, then ic read.
    @(posedge clk);
    #1;
    dc_wb_addr   = 32'h0000_3300;
    dc_wb_data   = wb_line(32'hCAFE_0000);
    dc_miss_addr = 32'h0000_4400;
    ic_miss_addr = 32'h0000_5500;
    push_xfer(2, dc_wb_addr, dc_wb_data);
    push_xfer(1, dc_miss_addr, '0);
    push_xfer(0, ic_miss_addr, '0);
    raise(2);
    raise(1);
    raise(0);
    wait_done("all_three");

    // dc_miss arrives mid ic fill; it waits for the ic ack.
    @(posedge clk);
    #1;
    ic_miss_addr = 32'h0000_6600;
    dc_miss_addr = 32'h0000_7700;
    push_xfer(0, ic_miss_addr, '0);
    raise(0);
    wait_beat(32'h0000_6610, "ic_beat2");
    push_xfer(1, dc_miss_addr, '0);
    raise(1);
    wait_done("late_dc");

    // Reset during beat 1 aborts the fill; the held request restarts at beat 0.
    @(posedge clk);
    #1;
    ic_miss_addr = 32'h0000_9900;
    push_xfer(0, ic_miss_addr, '0);
    raise(0);
    wait_beat(32'h0000_9908, "ic_beat1");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_beats.delete();
    exp_acks.delete();
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_ic_ack", ic_miss_ack, 1'b0);
    check("abort_fill_clr", ic_fill_data, 256'h0);
    push_xfer(0, ic_miss_addr, '0);
    wait_done("restart");

    // Both reads held for two grants each; the last grant after reset went to ic.
    @(posedge clk);
    #1;
    ic_miss_addr = 32'h0000_A000;
    dc_miss_addr = 32'h0000_B000;
    l_ic = 2;
    l_dc = 2;
    last = 0;
    while (l_ic > 0 || l_dc > 0) begin
      if (l_ic > 0 && l_dc > 0) pick = RR ? ((last == 0) ? 1 : 0) : 1;
      else pick = (l_dc > 0) ? 1 : 0;
      push_xfer(pick, (pick == 1) ? dc_miss_addr : ic_miss_addr, '0);
      last = pick;
      if (pick == 1) l_dc--;
      else l_ic--;
    end
    ic_raised += 2;
    dc_raised += 2;
    wait_done("held_reads");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
